div_32_bit: RTL
===============

Name: div_32_bit

Overview:
- Multi-cycle 32-bit restoring divider for the MIPS datapath; executes DIV (signed) and DIVU (unsigned).
- Each iteration forms a trial difference (partial remainder minus divisor) and keeps or restores it based on the sign of that difference.
- This is the same sign-of-difference decision the slt path makes, applied iteratively to produce quotient and remainder.
- Sits beside the ALU; results feed the HI/LO registers (remainder to HI, quotient to LO).

Parameters:
WIDTH, 32, operand/result width; the test plan exercises only 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
is_signed  input  1  1=DIV (two's complement), 0=DIVU
dividend  input  WIDTH  numerator; sampled on the accepting edge
divisor  input  WIDTH  denominator; sampled on the accepting edge
busy  output  1  high while an operation is in flight
done  output  1  single-cycle pulse: results valid
quotient  output  WIDTH  LO value; held until the next accepted start
remainder  output  WIDTH  HI value; held until the next accepted start
div_by_zero  output  1  set with done when divisor==0; held with results

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; all internal registers cleared.
- Reset mid-operation aborts immediately. No done is produced. The first legal start after rst_n rises is accepted normally.
- States: IDLE, PREP, DIV, FIX, DONE.
- Acceptance: start=1 on a rising edge while state is IDLE or DONE.
  - Latch dividend, divisor and is_signed; go to PREP.
  - start while busy=1 is ignored; the in-flight operation is unaffected.
- PREP (1 cycle):
  - If is_signed: take absolute values of both operands; record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Otherwise use the operands as-is with q_neg = r_neg = 0.
  - Clear the partial remainder; load the iteration counter with 31.
- DIV (exactly 32 cycles), one bit per cycle, MSB first:
  - Shift {rem, quo} left by 1, bringing in the next dividend bit.
  - Compute diff = rem_shifted - divisor as a 33-bit unsigned subtraction.
  - If diff is non-negative (no borrow): rem = diff and quotient bit = 1. Otherwise keep rem_shifted and set the bit to 0.
  - Counter decrements; leave for FIX after the count-0 iteration.
- FIX (1 cycle):
  - Negate quo if q_neg; negate rem if r_neg. Remainder sign always follows the dividend.
  - Write the quotient, remainder and div_by_zero outputs.
- DONE (1 cycle): done=1, busy=0. Next state is PREP if start is accepted this cycle, else IDLE.
- busy=1 in PREP, DIV and FIX; busy=0 in IDLE and DONE.
- Latency: start sampled at the end of cycle N → PREP N+1, DIV N+2..N+33, FIX N+34, done=1 in cycle N+35.
  - Fixed latency, independent of operand values.
  - Back-to-back issue (start accepted in DONE) gives a throughput of one result per 35 cycles.
- Divide by zero (divisor==0, signed or unsigned):
  - Full latency still applies.
  - quotient = 0xFFFFFFFF, remainder = dividend as sampled, div_by_zero = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0, div_by_zero = 0. No trap.
- Outputs change only in FIX or on reset. They are stable from done until the FIX of the next operation.
- done never asserts without a preceding accepted start.

Test Plan:
- Unsigned 100 / 7 → done at cycle N+35; quotient=14, remainder=2, div_by_zero=0.
- Signed sign combinations:
  - -7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
  - -7 / -2 → quotient=3, remainder=0xFFFFFFFF.
- Signedness of the same bits:
  - Unsigned 0xFFFFFFFF / 0x10 → quotient=0x0FFFFFFF, remainder=0xF.
  - Signed 0xFFFFFFFF / 0x10 → quotient=0, remainder=0xFFFFFFFF.
- Edge operands:
  - Divide by zero, dividend 0x1234 → quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Handshake:
  - Pulse start again at N+10 with other operands → ignored; the first result is correct at N+35.
  - start held during DONE → second result done at N+70.
- Reset:
  - Drop rst_n at N+20 → busy, done, outputs = 0 immediately; no done follows.
  - Fresh 100 / 7 after reset → quotient=14, remainder=2.

Source files
------------

// File: rtl/div_32_bit.sv
// div_32_bit: multi-cycle restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
module div_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, rem, quo, a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0] rs, df;
  logic [CW-1:0] cnt;
  logic sgn, q_neg, r_neg;
  // df[WIDTH] is the borrow of the trial subtraction: set means restore
  always_comb begin
    rs = {rem, quo[WIDTH-1]};
    df = rs - {1'b0, b_r};
    a_abs = (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
    b_abs = (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
    q_fix = q_neg ? -quo : quo;
    r_fix = r_neg ? -rem : rem;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= start ? PREP : IDLE;
          busy <= start;
          if (start) begin
            a_r <= dividend;
            b_r <= divisor;
            sgn <= is_signed;
          end
        end
        PREP: begin
          quo <= a_abs;
          b_r <= b_abs;
          rem <= '0;
          q_neg <= sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          r_neg <= sgn & a_r[WIDTH-1];
          cnt <= CW'(WIDTH - 1);
          state <= DIV;
        end
        DIV: begin
          rem <= df[WIDTH] ? rs[WIDTH-1:0] : df[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~df[WIDTH]};
          cnt <= cnt - 1'b1;
          state <= (cnt == '0) ? FIX : DIV;
        end
        FIX: begin
          quotient <= (b_r == '0) ? '1 : q_fix;
          remainder <= (b_r == '0) ? a_r : r_fix;
          div_by_zero <= (b_r == '0);
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
